// File: rtl/wb_daq_dma_sequencer_if.sv
// rtl/wb_daq_dma_sequencer_if.sv - command port between the DAQ write sequencer and the WB bus master
//
// Signals:
//   start      one-cycle command pulse towards the bus master
//   address    write byte address
//   selection  byte lanes
//   write      write strobe, high together with start
//   data_wr    write data
//   active     bus master busy flag
// Modports: master = sequencer side, slave = bus master side.

interface wb_daq_dma_sequencer_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic          start;
    logic [aw-1:0] address;
    logic [3:0]    selection;
    logic          write;
    logic [dw-1:0] data_wr;
    logic          active;

    modport master (
        output start, address, selection, write, data_wr,
        input  active
    );

    modport slave (
        input  start, address, selection, write, data_wr,
        output active
    );
endinterface

// File: rtl/wb_daq_dma_sequencer.sv
// rtl/wb_daq_dma_sequencer.sv - round-robin multi-channel sample-to-memory write sequencer
//
// Ports:
//   wb_clk, wb_rst_n  clock, asynchronous active-low reset
//   control_reg       bit0 global enable, bit1 clear pointers, bits[8+i] channel i enable
//   ch_valid/ch_data  per-channel sample offer (channel i data at [i*dw +: dw])
//   ch_ready          one-cycle pulse: sample of channel i accepted
//   buf_wrap          one-cycle pulse: channel i buffer pointer wrapped to 0
//   busy              high whenever the sequencer is not idle
//   bus               command port to the WB bus master (master modport)

module wb_daq_dma_sequencer #(
    parameter int            dw        = 32,
    parameter int            aw        = 32,
    parameter int            NUM_CH    = 4,
    parameter logic [aw-1:0] BASE_ADDR = '0,
    parameter int            BUF_WORDS = 256
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst_n,
    input  logic [dw-1:0]          control_reg,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic [NUM_CH*dw-1:0]   ch_data,
    output logic [NUM_CH-1:0]      ch_ready,
    output logic [NUM_CH-1:0]      buf_wrap,
    output logic                   busy,
    wb_daq_dma_sequencer_if.master bus
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(BUF_WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACT, WAIT_DONE} state_t;

    state_t          state, state_next;
    logic [GW-1:0]   last_grant, grant, pick;
    logic [PW-1:0]   ptr [NUM_CH];
    logic [NUM_CH-1:0] elig;
    logic            found, take, clear_now, done;
    logic            clear_pend;
    logic            start_q;
    logic [aw-1:0]   address_q, addr_calc;
    logic [dw-1:0]   data_q;
    int              idx;
    logic            unused_ctrl;

    // Only bits 0, 1 and the channel enables are meaningful.
    assign unused_ctrl = ^control_reg;

    assign elig = ch_valid & control_reg[8 +: NUM_CH] & {NUM_CH{control_reg[0]}};

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign addr_calc = BASE_ADDR
                     + ((aw'(pick) * aw'(BUF_WORDS) + aw'(ptr[pick])) << 2);

    always_comb begin
        state_next = state;
        take       = 1'b0;
        clear_now  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // A clear (live or deferred from a busy period) takes the
                // whole IDLE cycle; granting resumes the cycle after.
                if (control_reg[1] || clear_pend) begin
                    clear_now = 1'b1;
                end else if (found) begin
                    take       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:     state_next = WAIT_ACT;
            WAIT_ACT:  if (bus.active) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (!bus.active) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_next;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            last_grant <= GW'(NUM_CH - 1);
            grant      <= '0;
            ch_ready   <= '0;
            buf_wrap   <= '0;
            busy       <= 1'b0;
            start_q    <= 1'b0;
            address_q  <= '0;
            data_q     <= '0;
            clear_pend <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) ptr[i] <= '0;
        end else begin
            ch_ready <= '0;
            buf_wrap <= '0;
            start_q  <= (state == ISSUE);
            busy     <= (state_next != IDLE);

            if (take) begin
                grant           <= pick;
                address_q       <= addr_calc;
                data_q          <= ch_data[pick*dw +: dw];
                ch_ready[pick]  <= 1'b1;
            end

            if (state != IDLE && control_reg[1]) clear_pend <= 1'b1;

            if (done) begin
                ptr[grant] <= ptr[grant] + 1'b1;
                if (ptr[grant] == PW'(BUF_WORDS - 1)) buf_wrap[grant] <= 1'b1;
                last_grant <= grant;
            end

            if (clear_now) begin
                clear_pend <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) ptr[i] <= '0;
            end
        end
    end

    assign bus.start     = start_q;
    assign bus.write     = start_q;
    assign bus.address   = address_q;
    assign bus.data_wr   = data_q;
    assign bus.selection = 4'hF;
endmodule

// File: tb/tb_wb_daq_dma_sequencer.sv
// tb/tb_wb_daq_dma_sequencer.sv - scoreboard bench for wb_daq_dma_sequencer (NUM_CH=4, BUF_WORDS=4)

module tb_wb_daq_dma_sequencer;
    localparam int          NCH  = 4;
    localparam int          BW   = 4;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [31:0]       ctrl  = '0;
    logic [NCH-1:0]    ch_valid = '0;
    logic [NCH*32-1:0] ch_data  = '0;
    logic [NCH-1:0]    ch_ready, buf_wrap;
    logic              busy;

    wb_daq_dma_sequencer_if #(.aw(32), .dw(32)) bus ();

    wb_daq_dma_sequencer #(
        .dw(32), .aw(32), .NUM_CH(NCH), .BASE_ADDR(BASE), .BUF_WORDS(BW)
    ) dut (
        .wb_clk(clk), .wb_rst_n(rst_n), .control_reg(ctrl),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .buf_wrap(buf_wrap), .busy(busy), .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    int  rdy_q[$];

    int n_checks = 0, n_err = 0;
    int cyc = 0, n_starts = 0, start_cyc = 0, ready_cyc = 0, idle_cyc = 0, last_gap = 0, wrap_at = 0;
    int wrap_cnt[NCH];
    bit prev_busy = 0;

    logic [31:0] src_data[NCH][16];
    int src_n[NCH], src_rd[NCH];

    int act_delay = 0, busy_len = 3, dly = 0, hcnt = 0;
    bit pend = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic load(int ch, logic [31:0] d);
        src_data[ch][src_n[ch]] = d;
        src_n[ch]++;
    endtask

    task automatic expect_wr(int ch, logic [31:0] a, logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        rdy_q.push_back(ch);
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || rdy_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_idle: timeout, %0d writes still expected", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_starts(int target, int budget);
        int n = 0;
        while (n_starts < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_start: timeout, starts=%0d expected %0d", n_starts, target);
        end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_start"},    32'(bus.start),     32'h0);
        check({tag, "_write"},    32'(bus.write),     32'h0);
        check({tag, "_ch_ready"}, 32'(ch_ready),      32'h0);
        check({tag, "_buf_wrap"}, 32'(buf_wrap),      32'h0);
        check({tag, "_busy"},     32'(busy),          32'h0);
        check({tag, "_address"},  bus.address,        32'h0);
        check({tag, "_data_wr"},  bus.data_wr,        32'h0);
        check({tag, "_sel"},      32'(bus.selection), 32'hF);
    endtask

    task automatic clear_ptrs();
        @(posedge clk); #1 ctrl = ctrl | 32'h2;
        @(posedge clk); #1 ctrl = ctrl & ~32'h2;
        @(posedge clk); #1;
    endtask

    always @(posedge clk) cyc++;

    // Channel sources: advance on each ch_ready, keep valid while samples remain.
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst_n && ch_ready[i]) src_rd[i]++;
            ch_valid[i]          = (src_rd[i] < src_n[i]);
            ch_data[i*32 +: 32]  = (src_rd[i] < src_n[i]) ? src_data[i][src_rd[i]] : 32'h0;
        end
    end

    // Bus master model: active rises act_delay cycles after start, held busy_len cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.active = 1'b0;
            pend = 0;
            hcnt = 0;
        end else begin
            if (bus.start) begin
                pend = 1;
                dly  = act_delay;
            end
            if (pend) begin
                if (dly == 0) begin
                    bus.active = 1'b1;
                    hcnt = busy_len;
                    pend = 0;
                end else dly--;
            end else if (bus.active) begin
                if (hcnt <= 1) bus.active = 1'b0;
                else hcnt--;
            end
        end
    end

    // Monitor: compare every command and accept pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 0;
        end else begin
            if (bus.start) begin
                n_starts++;
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL start_unexpected: address %h data %h, none expected", bus.address, bus.data_wr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_address", bus.address, e.addr);
                    check("wr_data", bus.data_wr, e.data);
                    check("wr_write", 32'(bus.write), 32'h1);
                    check("wr_sel", 32'(bus.selection), 32'hF);
                end
            end
            if (ch_ready != '0) begin
                ready_cyc = cyc;
                last_gap  = cyc - idle_cyc;
                if (rdy_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL ready_unexpected: ch_ready %b, none expected", ch_ready);
                end else begin
                    int ch;
                    ch = rdy_q.pop_front();
                    check("ch_ready", 32'(ch_ready), 32'(1 << ch));
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (buf_wrap[i]) begin
                    wrap_cnt[i]++;
                    wrap_at = n_starts;
                end
            end
            if (prev_busy && !busy) idle_cyc = cyc;
            prev_busy = busy;
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, w1, wall;
        for (int i = 0; i < NCH; i++) begin
            src_n[i] = 0; src_rd[i] = 0; wrap_cnt[i] = 0;
        end
        bus.active = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single sample plus latency; second sample lands at ptr 1
        @(posedge clk); #1;
        ctrl = 32'h0000_0F01;
        act_delay = 0; busy_len = 3;
        expect_wr(0, 32'h0001_0000, 32'hDEAD_BEEF);
        load(0, 32'hDEAD_BEEF);
        t0 = cyc;
        wait_idle(100);
        check("lat_ready", 32'(ready_cyc - t0), 32'd1);
        check("lat_start", 32'(start_cyc - t0), 32'd2);
        @(posedge clk); #1;
        expect_wr(0, 32'h0001_0004, 32'h1111_0001);
        load(0, 32'h1111_0001);
        wait_idle(100);

        // Round robin, last grant was ch0 so ch1 leads
        clear_ptrs();
        act_delay = 1; busy_len = 1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < NCH; c++)
                load(c, 32'hA000_0000 | (32'(c) << 24) | 32'(k));
        expect_wr(1, 32'h0001_0010, 32'hA100_0000);
        expect_wr(2, 32'h0001_0020, 32'hA200_0000);
        expect_wr(3, 32'h0001_0030, 32'hA300_0000);
        expect_wr(0, 32'h0001_0000, 32'hA000_0000);
        expect_wr(1, 32'h0001_0014, 32'hA100_0001);
        expect_wr(2, 32'h0001_0024, 32'hA200_0001);
        expect_wr(3, 32'h0001_0034, 32'hA300_0001);
        expect_wr(0, 32'h0001_0004, 32'hA000_0001);
        expect_wr(1, 32'h0001_0018, 32'hA100_0002);
        expect_wr(2, 32'h0001_0028, 32'hA200_0002);
        expect_wr(3, 32'h0001_0038, 32'hA300_0002);
        expect_wr(0, 32'h0001_0008, 32'hA000_0002);
        wait_idle(400);
        check("rr_gap", 32'(last_gap), 32'd1);

        // Wrap: 5 samples on ch1 with a 4-word buffer
        clear_ptrs();
        act_delay = 1; busy_len = 2;
        base = n_starts;
        w1   = wrap_cnt[1];
        wall = wrap_cnt[0] + wrap_cnt[1] + wrap_cnt[2] + wrap_cnt[3];
        for (int k = 0; k < 5; k++) load(1, 32'hB100_0000 | 32'(k));
        expect_wr(1, 32'h0001_0010, 32'hB100_0000);
        expect_wr(1, 32'h0001_0014, 32'hB100_0001);
        expect_wr(1, 32'h0001_0018, 32'hB100_0002);
        expect_wr(1, 32'h0001_001C, 32'hB100_0003);
        expect_wr(1, 32'h0001_0010, 32'hB100_0004);
        wait_idle(300);
        check("wrap_count_ch1", 32'(wrap_cnt[1] - w1), 32'd1);
        check("wrap_count_all", 32'(wrap_cnt[0] + wrap_cnt[1] + wrap_cnt[2] + wrap_cnt[3] - wall), 32'd1);
        check("wrap_after_write", 32'(wrap_at - base), 32'd4);

        // Clear while busy
        clear_ptrs();
        act_delay = 0; busy_len = 6;
        base = n_starts;
        load(0, 32'hC000_0000);
        load(0, 32'hC000_0001);
        load(0, 32'hC000_0002);
        expect_wr(0, 32'h0001_0000, 32'hC000_0000);
        expect_wr(0, 32'h0001_0004, 32'hC000_0001);
        expect_wr(0, 32'h0001_0000, 32'hC000_0002);
        wait_starts(base + 2, 200);
        @(posedge clk); #1 ctrl = ctrl | 32'h2;
        @(posedge clk); #1 ctrl = ctrl & ~32'h2;
        wait_idle(200);
        check("clear_gap", 32'(last_gap), 32'd2);

        // Global enable dropped during WAIT_ACT
        act_delay = 2; busy_len = 2;
        base = n_starts;
        load(0, 32'hD000_0000);
        load(0, 32'hD000_0001);
        expect_wr(0, 32'h0001_0004, 32'hD000_0000);
        wait_starts(base + 1, 100);
        @(posedge clk); #1 ctrl = 32'h0000_0F00;
        wait_idle(100);
        repeat (20) @(negedge clk);
        check("en_drop_starts", 32'(n_starts - base), 32'd1);
        check("en_drop_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        expect_wr(0, 32'h0001_0008, 32'hD000_0001);
        ctrl = 32'h0000_0F01;
        wait_idle(100);

        // Async reset in WAIT_DONE
        act_delay = 0; busy_len = 8;
        base = n_starts;
        load(2, 32'hE200_0000);
        expect_wr(2, 32'h0001_0020, 32'hE200_0000);
        wait_starts(base + 1, 100);
        repeat (3) @(posedge clk);
        #1 check("busy_mid", 32'(busy), 32'h1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        load(0, 32'hF000_0000);
        load(2, 32'hF200_0000);
        expect_wr(0, 32'h0001_0000, 32'hF000_0000);
        expect_wr(2, 32'h0001_0020, 32'hF200_0000);
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
